// File: rtl/debug_pkg.sv
// Shared types and constants for the debug master bridge: FSM state encoding,
// debug register map and counter widths.
package debug_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StRdWait,
    StResp
  } state_e;

  localparam logic [2:0] AddrReg0 = 3'd0;
  localparam logic [2:0] AddrReg1 = 3'd1;
  localparam logic [2:0] AddrReg2 = 3'd2;
  localparam logic [2:0] AddrData = 3'd3;

  localparam int unsigned TimeoutCntW = 16;
  // READ_LATENCY is limited to 1..4, so the reload value READ_LATENCY-1 fits in 2 bits.
  localparam int unsigned LatCntW     = 2;

endpackage

// File: rtl/debug_master_bridge_if.sv
// Host-side command/response channel of the debug master bridge.
// The host drives the master modport; the bridge uses the slave modport.
interface debug_master_bridge_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [2:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error
  );

endinterface

// File: rtl/debug_master_bridge.sv
// Converts single host commands into Avalon-MM master transfers, one outstanding
// command at a time, with fixed read latency and a waitrequest stall timeout.
module debug_master_bridge
  import debug_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic                  CLK,
  input  logic                  RST,
  debug_master_bridge_if.slave  host,
  output logic                  chipselect_debug,
  output logic [2:0]            adress_debug,
  output logic                  write_debug,
  output logic [31:0]           writedata_debug,
  output logic                  read_debug,
  input  logic [31:0]           readdata_debug,
  input  logic                  waitrequest_debug
);

  localparam logic [TimeoutCntW-1:0] TimeoutVal = TimeoutCntW'(TIMEOUT);
  localparam logic [LatCntW-1:0]     LatInit    = LatCntW'(READ_LATENCY - 1);

  state_e                 state_q, state_d;
  logic                   write_q, write_d;
  logic [2:0]             addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   error_q, error_d;
  logic [LatCntW-1:0]     lat_q, lat_d;
  logic [TimeoutCntW-1:0] tmo_q, tmo_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
      lat_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      lat_q   <= lat_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    error_d = error_q;
    lat_d   = lat_q;
    tmo_d   = tmo_q;

    unique case (state_q)
      StIdle: begin
        if (host.cmd_valid) begin
          write_d = host.cmd_write;
          addr_d  = host.cmd_addr;
          wdata_d = host.cmd_wdata;
          rdata_d = '0;
          error_d = 1'b0;
          tmo_d   = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        // A slave releasing waitrequest always wins over an expiring stall count.
        if (!waitrequest_debug) begin
          if (write_q) begin
            state_d = StResp;
          end else begin
            lat_d   = LatInit;
            state_d = StRdWait;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_d == TimeoutVal) begin
            error_d = 1'b1;
            state_d = StResp;
          end
        end
      end
      StRdWait: begin
        if (lat_q == '0) begin
          rdata_d = readdata_debug;
          state_d = StResp;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      StResp: begin
        if (host.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign host.cmd_ready = (state_q == StIdle);
  assign host.rsp_valid = (state_q == StResp);
  assign host.rsp_rdata = rdata_q;
  assign host.rsp_error = error_q;

  assign chipselect_debug = (state_q == StReq);
  assign read_debug       = (state_q == StReq) && !write_q;
  assign write_debug      = (state_q == StReq) && write_q;
  assign adress_debug     = addr_q;
  assign writedata_debug  = wdata_q;

endmodule

// File: tb/tb_debug_master_bridge.sv
// Randomized self-checking bench for debug_master_bridge against a transaction-level
// model: a register-file slave plus per-command timing derived from stalls and latency.
module tb_debug_master_bridge;
  import debug_pkg::*;

  localparam int unsigned Lat = 2;
  localparam int unsigned Tmo = 8;

  logic        CLK;
  logic        RST;
  logic        chipselect_debug;
  logic [2:0]  adress_debug;
  logic        write_debug;
  logic [31:0] writedata_debug;
  logic        read_debug;
  logic [31:0] readdata_debug;
  logic        waitrequest_debug;

  debug_master_bridge_if u_if ();

  debug_master_bridge #(
    .READ_LATENCY (Lat),
    .TIMEOUT      (Tmo)
  ) u_dut (
    .CLK               (CLK),
    .RST               (RST),
    .host              (u_if.slave),
    .chipselect_debug  (chipselect_debug),
    .adress_debug      (adress_debug),
    .write_debug       (write_debug),
    .writedata_debug   (writedata_debug),
    .read_debug        (read_debug),
    .readdata_debug    (readdata_debug),
    .waitrequest_debug (waitrequest_debug)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] mem [8];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle_bus(input string tag);
    check({tag, "_cs"}, 32'(chipselect_debug), 0);
    check({tag, "_rd"}, 32'(read_debug), 0);
    check({tag, "_wr"}, 32'(write_debug), 0);
  endtask

  // One complete command: accept, REQ with `stalls` waitrequest cycles, optional read
  // latency, RESP held `hold` cycles with a second command pending, then handshake.
  task automatic run_txn(input bit w, input logic [2:0] a, input logic [31:0] d,
                         input int unsigned stalls, input int unsigned hold);
    bit          err;
    int unsigned req_cycles;
    logic [31:0] exp_rd;
    err        = (stalls >= Tmo);
    req_cycles = err ? Tmo : stalls + 1;
    exp_rd     = (w || err) ? 32'h0 : mem[a];

    check("idle_ready", 32'(u_if.cmd_ready), 1);
    check("idle_rsp_valid", 32'(u_if.rsp_valid), 0);
    u_if.cmd_valid = 1'b1;
    u_if.cmd_write = w;
    u_if.cmd_addr  = a;
    u_if.cmd_wdata = d;
    step();
    u_if.cmd_valid = 1'b0;
    u_if.cmd_write = 1'($urandom_range(0, 1));
    u_if.cmd_addr  = 3'($urandom_range(0, 7));
    u_if.cmd_wdata = $urandom;

    for (int k = 0; k < int'(req_cycles); k++) begin
      check("req_cs", 32'(chipselect_debug), 1);
      check("req_rd", 32'(read_debug), 32'(!w));
      check("req_wr", 32'(write_debug), 32'(w));
      check("req_addr", 32'(adress_debug), 32'(a));
      check("req_wdata", writedata_debug, d);
      check("req_cmd_ready", 32'(u_if.cmd_ready), 0);
      waitrequest_debug = (k < int'(stalls));
      step();
    end
    waitrequest_debug = 1'b0;

    if (!w && !err) begin
      for (int k = 0; k < int'(Lat); k++) begin
        check_idle_bus("rdwait");
        check("rdwait_rsp_valid", 32'(u_if.rsp_valid), 0);
        readdata_debug = (k == int'(Lat) - 1) ? mem[a] : $urandom;
        step();
      end
      readdata_debug = $urandom;
    end
    if (w && !err) mem[a] = d;

    u_if.cmd_valid = (hold > 0);
    for (int k = 0; k < int'(hold); k++) begin
      check("hold_rsp_valid", 32'(u_if.rsp_valid), 1);
      check("hold_rdata", u_if.rsp_rdata, exp_rd);
      check("hold_error", 32'(u_if.rsp_error), 32'(err));
      check("hold_cmd_ready", 32'(u_if.cmd_ready), 0);
      check_idle_bus("hold");
      step();
    end
    check("rsp_valid", 32'(u_if.rsp_valid), 1);
    check("rsp_rdata", u_if.rsp_rdata, exp_rd);
    check("rsp_error", 32'(u_if.rsp_error), 32'(err));
    check_idle_bus("resp");
    u_if.rsp_ready = 1'b1;
    step();
    u_if.rsp_ready = 1'b0;
    u_if.cmd_valid = 1'b0;
    check("post_rsp_valid", 32'(u_if.rsp_valid), 0);
  endtask

  initial begin
    int unsigned r;
    int unsigned st;
    RST               = 1'b0;
    u_if.cmd_valid    = 1'b0;
    u_if.cmd_write    = 1'b0;
    u_if.cmd_addr     = '0;
    u_if.cmd_wdata    = '0;
    u_if.rsp_ready    = 1'b0;
    readdata_debug    = '0;
    waitrequest_debug = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = $urandom;
    mem[AddrReg0] = 32'h0000_00A5;

    step();
    step();
    check_idle_bus("rst");
    check("rst_rsp_valid", 32'(u_if.rsp_valid), 0);
    check("rst_rdata", u_if.rsp_rdata, 0);
    check("rst_error", 32'(u_if.rsp_error), 0);
    check("rst_addr", 32'(adress_debug), 0);
    check("rst_wdata", writedata_debug, 0);
    @(negedge CLK);
    RST = 1'b1;
    step();
    check("rst_cmd_ready", 32'(u_if.cmd_ready), 1);

    run_txn(1'b1, AddrReg1, 32'hDEAD_BEEF, 0, 0);
    run_txn(1'b0, AddrReg0, $urandom, 0, 0);
    run_txn(1'b1, AddrReg2, 32'h1234_5678, 3, 0);
    run_txn(1'b0, AddrData, $urandom, 20, 0);
    run_txn(1'b1, AddrData, 32'hCAFE_F00D, 7, 0);
    run_txn(1'b1, AddrReg1, 32'h5555_AAAA, 8, 0);
    run_txn(1'b0, AddrReg2, $urandom, 0, 5);
    run_txn(1'b0, AddrData, $urandom, 7, 2);

    // Asynchronous reset while a read is stalled in REQ.
    u_if.cmd_valid = 1'b1;
    u_if.cmd_write = 1'b0;
    u_if.cmd_addr  = AddrReg1;
    step();
    u_if.cmd_valid    = 1'b0;
    waitrequest_debug = 1'b1;
    check("mid_rd_strobe", 32'(read_debug), 1);
    step();
    step();
    #2;
    RST = 1'b0;
    #1;
    check_idle_bus("async_rst");
    check("async_rst_rsp_valid", 32'(u_if.rsp_valid), 0);
    waitrequest_debug = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("in_rst_rsp_valid", 32'(u_if.rsp_valid), 0);
    end
    @(negedge CLK);
    RST = 1'b1;
    step();
    check("after_rst_rsp_valid", 32'(u_if.rsp_valid), 0);
    run_txn(1'b0, AddrReg1, $urandom, 0, 0);

    for (int n = 0; n < 60; n++) begin
      r  = $urandom_range(0, 9);
      st = (r < 4) ? 0 : (r < 8) ? $urandom_range(1, 7) : $urandom_range(8, 12);
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, st,
              $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
